// File: rtl/combo_lock_fsm.sv
// Combination-lock control core: debounced digit entry, code compare, alarm
// lockout and change-password sequencing, with a registered 3-bit display code.
module combo_lock_fsm #(
  parameter int                          DIGITS       = 4,
  parameter int                          DIGIT_W      = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE = 16'h1234,
  parameter int                          MAX_TRIES    = 3,
  parameter int                          OPEN_CYCLES  = 50000000,
  parameter int                          ALARM_CYCLES = 250000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               change,
  input  logic               lock,
  output logic [2:0]         state,
  output logic               unlocked,
  output logic               alarm,
  output logic [1:0]         fails
);

  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int TMR_MAX = (OPEN_CYCLES > ALARM_CYCLES) ? OPEN_CYCLES : ALARM_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] ALARM_LAST = TMR_W'(ALARM_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [2:0]       TRIES_LIM  = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_LOCKED = 3'b000,
    ST_ENTRY  = 3'b001,
    ST_ALARM  = 3'b010,
    ST_NEWPW  = 3'b011,
    ST_OPEN   = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         fails_q, fails_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  digits_q, digits_d;
  logic               enter_prev_q, enter_prev_d;
  logic               change_prev_q, change_prev_d;
  logic               unlocked_q, unlocked_d;
  logic               alarm_q, alarm_d;

  logic               press;
  logic               chg_press;
  logic               digits_we;
  logic [CODE_W-1:0]  full_code;

  always_comb begin
    press         = enter & ~enter_prev_q;
    chg_press     = change & ~change_prev_q;
    enter_prev_d  = enter;
    change_prev_d = change;
    // The final digit is still on the input, so splice it in for same-cycle compare/load.
    full_code     = {digits_q[CODE_W-1:DIGIT_W], digit};

    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    fails_d   = fails_q;
    code_d    = code_q;
    digits_we = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        idx_d = '0;
        if (press) begin
          digits_we = 1'b1;
          idx_d     = IDX_W'(1);
          state_d   = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (press) begin
          digits_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (full_code == code_q) begin
              state_d = ST_OPEN;
              fails_d = '0;
            end else if (({1'b0, fails_q} + 3'd1) == TRIES_LIM) begin
              state_d = ST_ALARM;
            end else begin
              fails_d = fails_q + 2'd1;
              state_d = ST_LOCKED;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_ALARM: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == ALARM_LAST) begin
          state_d = ST_LOCKED;
          fails_d = '0;
        end
      end
      ST_OPEN: begin
        timer_d = timer_q + 1'b1;
        if (lock) begin
          state_d = ST_LOCKED;
        end else if (chg_press) begin
          state_d = ST_NEWPW;
          idx_d   = '0;
        end else if (timer_q == OPEN_LAST) begin
          state_d = ST_LOCKED;
        end
      end
      ST_NEWPW: begin
        if (lock) begin
          state_d = ST_LOCKED;
          idx_d   = '0;
        end else if (press) begin
          digits_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            code_d  = full_code;
            idx_d   = '0;
            state_d = ST_OPEN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOCKED;
        idx_d   = '0;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    // First-entered digit lands in the most significant slot.
    digits_d = digits_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_we && (idx_q == IDX_W'(i)))
        digits_d[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit;
    end

    unlocked_d = (state_d == ST_OPEN) || (state_d == ST_NEWPW);
    alarm_d    = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_LOCKED;
      idx_q         <= '0;
      timer_q       <= '0;
      fails_q       <= '0;
      code_q        <= DEFAULT_CODE;
      enter_prev_q  <= 1'b1;
      change_prev_q <= 1'b1;
      unlocked_q    <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      fails_q       <= fails_d;
      code_q        <= code_d;
      enter_prev_q  <= enter_prev_d;
      change_prev_q <= change_prev_d;
      unlocked_q    <= unlocked_d;
      alarm_q       <= alarm_d;
    end
  end

  // Entry buffer is pure data: every slot is rewritten before it is ever compared.
  always_ff @(posedge clk) begin
    digits_q <= digits_d;
  end

  assign state    = state_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;
  assign fails    = fails_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: table vectors, directed multi-cycle sequences and
// randomized traffic checked against a queue-based behavioural model.
module tb_combo_lock_fsm;

  localparam int DIGITS       = 4;
  localparam int DIGIT_W      = 4;
  localparam int MAX_TRIES    = 3;
  localparam int OPEN_CYCLES  = 20;
  localparam int ALARM_CYCLES = 10;

  logic               clk;
  logic               resetn;
  logic [DIGIT_W-1:0] digit;
  logic               enter, change, lock;
  logic [2:0]         state;
  logic               unlocked, alarm;
  logic [1:0]         fails;

  int n_vec = 0;
  int n_err = 0;

  combo_lock_fsm #(
    .DIGITS      (DIGITS),
    .DIGIT_W     (DIGIT_W),
    .DEFAULT_CODE(16'h1234),
    .MAX_TRIES   (MAX_TRIES),
    .OPEN_CYCLES (OPEN_CYCLES),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .digit   (digit),
    .enter   (enter),
    .change  (change),
    .lock    (lock),
    .state   (state),
    .unlocked(unlocked),
    .alarm   (alarm),
    .fails   (fails)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  localparam int M_LOCKED = 0, M_ENTRY = 1, M_ALARM = 2, M_OPEN = 3, M_NEWPW = 4;

  int m_mode;
  int m_entry[$];
  int m_code[$];
  int m_fails;
  int m_left;
  bit m_prev_e, m_prev_c;

  task automatic model_reset();
    m_mode  = M_LOCKED;
    m_entry.delete();
    m_code  = '{1, 2, 3, 4};
    m_fails = 0;
    m_left  = 0;
    m_prev_e = 1'b1;
    m_prev_c = 1'b1;
  endtask

  function automatic bit entry_matches();
    for (int i = 0; i < DIGITS; i++)
      if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit e, input bit c, input bit l, input int d);
    bit pe, pc;
    pe = e && !m_prev_e;
    pc = c && !m_prev_c;
    m_prev_e = e;
    m_prev_c = c;
    case (m_mode)
      M_LOCKED, M_ENTRY: begin
        if (pe) begin
          m_entry.push_back(d);
          m_mode = M_ENTRY;
          if (m_entry.size() == DIGITS) begin
            if (entry_matches()) begin
              m_mode = M_OPEN; m_fails = 0; m_left = OPEN_CYCLES;
            end else if (m_fails + 1 == MAX_TRIES) begin
              m_mode = M_ALARM; m_left = ALARM_CYCLES;
            end else begin
              m_fails++; m_mode = M_LOCKED;
            end
            m_entry.delete();
          end
        end
      end
      M_ALARM: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_LOCKED; m_fails = 0; end
      end
      M_OPEN: begin
        m_left--;
        if (l) m_mode = M_LOCKED;
        else if (pc) begin m_mode = M_NEWPW; m_entry.delete(); end
        else if (m_left == 0) m_mode = M_LOCKED;
      end
      M_NEWPW: begin
        if (l) begin m_mode = M_LOCKED; m_entry.delete(); end
        else if (pe) begin
          m_entry.push_back(d);
          if (m_entry.size() == DIGITS) begin
            m_code = m_entry;
            m_entry.delete();
            m_mode = M_OPEN; m_left = OPEN_CYCLES;
          end
        end
      end
      default: m_mode = M_LOCKED;
    endcase
  endtask

  function automatic logic [2:0] mode_code(input int mode);
    case (mode)
      M_ENTRY: return 3'b001;
      M_ALARM: return 3'b010;
      M_NEWPW: return 3'b011;
      M_OPEN:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got st/unl/alm/fails=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [6:0] exp;
    logic [6:0] act;
    exp = {mode_code(m_mode), (m_mode == M_OPEN) || (m_mode == M_NEWPW),
           m_mode == M_ALARM, 2'(m_fails)};
    act = {state, unlocked, alarm, fails};
    // The fail count while alarmed is left undefined, so only the rest is compared there.
    if (m_mode == M_ALARM) begin
      exp[1:0] = 2'b00;
      act[1:0] = 2'b00;
    end
    chk("model", act, exp);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit e, input bit c, input bit l, input int d);
    enter  = e;
    change = c;
    lock   = l;
    digit  = DIGIT_W'(d);
    model_step(e, c, l, d);
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic press_digit(input int d);
    cycle(1'b1, 1'b0, 1'b0, d);
    cycle(1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    press_digit(a); press_digit(b); press_digit(c); press_digit(d);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases on a falling edge.
  task automatic do_reset(input bit hold_enter);
    #2;
    enter  = hold_enter;
    change = 1'b0;
    lock   = 1'b0;
    resetn = 1'b0;
    #1;
    chk("reset_async", {state, unlocked, alarm, fails}, 7'b0000000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    bit         e, c, l;
    int         d;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int d;
    // Correct code 1,2,3,4 from LOCKED with the release cycles in between.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 7'b0010000});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 7'b0010000});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2, 7'b0010000});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2, 7'b0010000});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3, 7'b0010000});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3, 7'b0010000});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4, 7'b1001000});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4, 7'b1001000});

    resetn = 1'b1;
    enter  = 1'b0;
    change = 1'b0;
    lock   = 1'b0;
    digit  = '0;
    model_reset();

    do_reset(1'b0);
    cycle(0, 0, 0, 0);
    chk("idle_after_reset", {state, unlocked, alarm, fails}, 7'b0000000);

    foreach (tbl[i]) begin
      cycle(tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].d);
      chk($sformatf("tbl%0d", i), {state, unlocked, alarm, fails}, tbl[i].exp);
    end

    // OPEN entered on the 4th press; one release cycle already elapsed.
    repeat (18) cycle(0, 0, 0, 0);
    chk("open_before_timeout", {state, unlocked, alarm, fails}, 7'b1001000);
    cycle(0, 0, 0, 0);
    chk("open_timeout", {state, unlocked, alarm, fails}, 7'b0000000);

    // Three wrong codes.
    enter_code(1, 2, 3, 5);
    chk("wrong1", {state, unlocked, alarm, fails}, 7'b0000001);
    enter_code(1, 2, 3, 5);
    chk("wrong2", {state, unlocked, alarm, fails}, 7'b0000010);
    enter_code(1, 2, 3, 5);
    chk("alarm_on", {state, unlocked, alarm, 2'b00}, 7'b0100100);
    for (int k = 0; k < 8; k++) cycle(k[0], k[0], 1'b1, 1);
    chk("alarm_hold", {state, unlocked, alarm, 2'b00}, 7'b0100100);
    cycle(0, 0, 0, 0);
    chk("alarm_end", {state, unlocked, alarm, fails}, 7'b0000000);
    enter_code(1, 2, 3, 4);
    chk("open_after_alarm", {state, unlocked, alarm, fails}, 7'b1001000);

    // Enter held through reset release, then held for five cycles.
    do_reset(1'b1);
    repeat (3) cycle(1, 0, 0, 7);
    chk("held_through_reset", {state, unlocked, alarm, fails}, 7'b0000000);
    cycle(0, 0, 0, 0);
    repeat (5) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    press_digit(2);
    press_digit(3);
    chk("held_one_digit", {state, unlocked, alarm, fails}, 7'b0010000);
    press_digit(4);
    chk("held_open", {state, unlocked, alarm, fails}, 7'b1001000);

    // Code change to 9876.
    cycle(0, 1, 0, 0);
    chk("newpw_enter", {state, unlocked, alarm, fails}, 7'b0111000);
    cycle(0, 0, 0, 0);
    press_digit(9); press_digit(8); press_digit(7);
    chk("newpw_partial", {state, unlocked, alarm, fails}, 7'b0111000);
    press_digit(6);
    chk("newpw_done", {state, unlocked, alarm, fails}, 7'b1001000);
    cycle(0, 0, 1, 0);
    chk("relock", {state, unlocked, alarm, fails}, 7'b0000000);
    enter_code(1, 2, 3, 4);
    chk("old_code_rejected", {state, unlocked, alarm, fails}, 7'b0000001);
    enter_code(9, 8, 7, 6);
    chk("new_code_opens", {state, unlocked, alarm, fails}, 7'b1001000);

    // lock and change together in OPEN: lock wins.
    cycle(0, 1, 1, 0);
    chk("lock_over_change", {state, unlocked, alarm, fails}, 7'b0000000);

    // Aborted code change keeps the default code.
    do_reset(1'b0);
    cycle(0, 0, 0, 0);
    enter_code(1, 2, 3, 4);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    press_digit(5); press_digit(6);
    chk("abort_in_newpw", {state, unlocked, alarm, fails}, 7'b0111000);
    cycle(0, 0, 1, 0);
    chk("abort_lock", {state, unlocked, alarm, fails}, 7'b0000000);
    enter_code(1, 2, 3, 4);
    chk("abort_code_kept", {state, unlocked, alarm, fails}, 7'b1001000);
    cycle(0, 0, 1, 0);

    // Async reset mid-entry after the code was changed.
    cycle(0, 1, 0, 0);
    chk("newpw_before_reset", {state, unlocked, alarm, fails}, 7'b0000000);
    enter_code(1, 2, 3, 4);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    enter_code(5, 5, 5, 5);
    cycle(0, 0, 1, 0);
    press_digit(5); press_digit(5);
    chk("mid_entry", {state, unlocked, alarm, fails}, 7'b0010000);
    do_reset(1'b0);
    cycle(0, 0, 0, 0);
    enter_code(1, 2, 3, 4);
    chk("default_after_reset", {state, unlocked, alarm, fails}, 7'b1001000);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ((m_mode == M_LOCKED || m_mode == M_ENTRY) && ($urandom % 4 != 0))
        d = m_code[m_entry.size()];
      else
        d = int'($urandom % 16);
      cycle(1'($urandom % 2), ($urandom % 6) == 0, ($urandom % 40) == 0, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
